// File: rtl/hififo_pkg.sv
// Shared types and constants for the read-request scheduler.
// Page size, bus widths, descriptor layout and FSM encoding.
package hififo_pkg;

    localparam int PAGE_QW = 512;
    localparam int NCH     = 8;
    localparam int ADDR_W  = 61;
    localparam int CNT_W   = 19;
    localparam int LEN_W   = 10;

    function automatic int tag_w(input int tags);
        return (tags <= 2) ? 1 : $clog2(tags);
    endfunction

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  count;
    } desc_t;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/hififo_tag_pool.sv
// Completion-tag pool: free vector, lowest-free pick; a freed tag is allocatable the next cycle.
// With HIFIFO_READ_SCHED_TAG_CHECK_EN, bad frees and channel strobe errors raise a sticky err_o.
module hififo_tag_pool #(
    parameter int TAGS  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_i,
    input  logic [TAG_W-1:0] alloc_tag_i,
    input  logic             free_vld_i,
    input  logic [TAG_W-1:0] free_tag_i,
`ifdef HIFIFO_READ_SCHED_TAG_CHECK_EN
    input  logic             chan_err_i,
`endif
    output logic             any_free_o,
    output logic [TAG_W-1:0] low_free_o,
    output logic             err_o
);

    logic [TAGS-1:0] free_q;
    logic [TAGS-1:0] free_d;
    logic            free_ok;

    always_comb begin
        // Returning a tag that is already free (or out of range) is dropped.
        free_ok = free_vld_i && (int'(free_tag_i) < TAGS) && !free_q[free_tag_i];
        free_d  = free_q;
        if (alloc_i) begin
            free_d[alloc_tag_i] = 1'b0;
        end
        if (free_ok) begin
            free_d[free_tag_i] = 1'b1;
        end
        any_free_o = |free_q;
        low_free_o = '0;
        for (int i = TAGS - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                low_free_o = TAG_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_q <= '1;
        end else begin
            free_q <= free_d;
        end
    end

`ifdef HIFIFO_READ_SCHED_TAG_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((free_vld_i && !free_ok) || chan_err_i) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/hififo_read_sched.sv
// Splits per-channel descriptors into MRRS/4KB-bounded reads, round-robin per request, one request per 2 cycles.
// rq outputs hold while rq_ready is low; stalls in ARB when no tag is free. Optional HIFIFO_READ_SCHED_TAG_CHECK_EN.
module hififo_read_sched
    import hififo_pkg::*;
#(
    parameter logic [NCH-1:0] ENABLES = 8'b0001_0001,
    parameter int             MRRS_QW = 64,
    parameter int             TAGS    = 32,
    localparam int            TAG_W   = tag_w(TAGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    r_valid_i,
    input  logic [ADDR_W-1:0] r_addr_i,
    input  logic [CNT_W-1:0]  r_count_i,
    output logic [NCH-1:0]    r_ready_o,
    output logic              rq_valid_o,
    input  logic              rq_ready_i,
    output logic [ADDR_W-1:0] rq_addr_o,
    output logic [LEN_W-1:0]  rq_len_o,
    output logic [TAG_W-1:0]  rq_tag_o,
    output logic [2:0]        rq_chan_o,
    input  logic              tag_free_valid_i,
    input  logic [TAG_W-1:0]  tag_free_i,
    output logic [NCH-1:0]    desc_done_o,
    output logic              err_tag_o
);

    desc_t             slot_q [NCH];
    desc_t             slot_d [NCH];
    logic [NCH-1:0]    busy_q, busy_d;
    logic [NCH-1:0]    rdy_q;
    logic [NCH-1:0]    done_q, done_d;
    state_e            state_q;
    logic [2:0]        last_q;
    logic [ADDR_W-1:0] rq_addr_q;
    logic [LEN_W-1:0]  rq_len_q;
    logic [TAG_W-1:0]  rq_tag_q;
    logic [2:0]        rq_chan_q;

    logic              accept;
    logic              gnt_vld;
    logic [2:0]        gnt_ch;
    logic [2:0]        cand;
    logic [CNT_W:0]    page_room;
    logic [CNT_W:0]    len_min;
    logic              any_free;
    logic [TAG_W-1:0]  low_free;

    assign accept = (state_q == ST_ISSUE) && rq_ready_i;

    always_comb begin
        slot_d = slot_q;
        busy_d = busy_q;
        done_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_valid_i[i] && ENABLES[i] && !busy_q[i]) begin
                if (r_count_i == '0) begin
                    done_d[i] = 1'b1;
                end else begin
                    slot_d[i].addr  = r_addr_i;
                    slot_d[i].count = r_count_i;
                    busy_d[i]       = 1'b1;
                end
            end
        end
        if (accept) begin
            slot_d[rq_chan_q].addr  = slot_q[rq_chan_q].addr + ADDR_W'(rq_len_q);
            slot_d[rq_chan_q].count = slot_q[rq_chan_q].count - CNT_W'(rq_len_q);
            if (slot_q[rq_chan_q].count == CNT_W'(rq_len_q)) begin
                busy_d[rq_chan_q] = 1'b0;
                done_d[rq_chan_q] = 1'b1;
            end
        end
    end

    // Scan downward so the nearest busy channel after the last grant wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = last_q;
        cand    = '0;
        for (int k = NCH; k >= 1; k--) begin
            cand = last_q + 3'(k);
            if (busy_q[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
        page_room = (CNT_W+1)'(PAGE_QW) - (CNT_W+1)'(slot_q[gnt_ch].addr[8:0]);
        len_min   = {1'b0, slot_q[gnt_ch].count};
        if (len_min > (CNT_W+1)'(MRRS_QW)) begin
            len_min = (CNT_W+1)'(MRRS_QW);
        end
        if (len_min > page_room) begin
            len_min = page_room;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                slot_q[i] <= '0;
            end
            busy_q <= '0;
            rdy_q  <= '0;
            done_q <= '0;
        end else begin
            slot_q <= slot_d;
            busy_q <= busy_d;
            rdy_q  <= ENABLES & ~busy_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ARB;
            last_q    <= 3'd7;
            rq_addr_q <= '0;
            rq_len_q  <= '0;
            rq_tag_q  <= '0;
            rq_chan_q <= '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (gnt_vld && any_free) begin
                        state_q   <= ST_ISSUE;
                        last_q    <= gnt_ch;
                        rq_chan_q <= gnt_ch;
                        rq_addr_q <= slot_q[gnt_ch].addr;
                        rq_len_q  <= LEN_W'(len_min);
                        rq_tag_q  <= low_free;
                    end
                end
                ST_ISSUE: begin
                    if (rq_ready_i) begin
                        state_q <= ST_ARB;
                    end
                end
            endcase
        end
    end

`ifdef HIFIFO_READ_SCHED_TAG_CHECK_EN
    logic chan_err;
    assign chan_err = |(r_valid_i & (busy_q | ~ENABLES));
`endif

    hififo_tag_pool #(
        .TAGS  (TAGS),
        .TAG_W (TAG_W)
    ) u_tag_pool (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_i     (accept),
        .alloc_tag_i (rq_tag_q),
        .free_vld_i  (tag_free_valid_i),
        .free_tag_i  (tag_free_i),
`ifdef HIFIFO_READ_SCHED_TAG_CHECK_EN
        .chan_err_i  (chan_err),
`endif
        .any_free_o  (any_free),
        .low_free_o  (low_free),
        .err_o       (err_tag_o)
    );

    assign r_ready_o   = rdy_q;
    assign rq_valid_o  = (state_q == ST_ISSUE);
    assign rq_addr_o   = rq_addr_q;
    assign rq_len_o    = rq_len_q;
    assign rq_tag_o    = rq_tag_q;
    assign rq_chan_o   = rq_chan_q;
    assign desc_done_o = done_q;

endmodule

// File: doc/hififo_read_sched.md
# hififo_read_sched

Read-request scheduler between the per-channel page-table request queues and the PCIe TLP transmit path. Captures one (address, qword count) descriptor per enabled channel, arbitrates round-robin among channels, splits each descriptor into memory-read requests bounded by the max read request size and 4 KB boundaries, and allocates a completion tag for each request from a shared pool.

## Interface
- ENABLES, 8'b00010001, channel enable mask; disabled channels never assert r_ready and ignore r_valid
- MRRS_QW, 64, max read request in qwords (power of 2, 16..512)
- TAGS, 32, tag pool size (power of 2, ≤32)
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- r_valid  in  8  one-cycle descriptor strobe per channel, at most one bit set
- r_addr  in  61  descriptor start, qword address (shared bus)
- r_count  in  19  descriptor length in qwords (shared bus)
- r_ready  out  8  channel descriptor slot free
- rq_valid  out  1  read request valid
- rq_ready  in  1  transmit path accepts request
- rq_addr  out  61  request qword address
- rq_len  out  10  request length in qwords, 1..MRRS_QW
- rq_tag  out  log2(TAGS)  allocated tag
- rq_chan  out  3  originating channel
- tag_free_valid  in  1  completion unit returns a tag
- tag_free  in  log2(TAGS)  returned tag
- desc_done  out  8  one-cycle pulse: last request of channel's descriptor accepted
- err_tag  out  1  sticky tag error (see Configuration)

## Operation
- Per enabled channel: one descriptor slot {addr, remaining}. r_valid[i] loads slot and marks it busy; r_ready[i] = registered ~busy[i].
- r_count == 0: slot not loaded, desc_done[i] pulses next cycle, r_ready stays high.
- FSM states: ARB, ISSUE.
- ARB: if no busy slot or no free tag, stay. Else grant lowest busy channel above last grant (wrapping), register rq_addr = slot.addr, rq_chan, rq_tag = lowest-numbered free tag, rq_len = min(remaining, MRRS_QW, 512 − addr[8:0]); go ISSUE.
- ISSUE: rq_valid high, outputs stable until rq_valid & rq_ready. On accept: mark tag in use, addr += rq_len, remaining −= rq_len; if remaining reaches 0, clear busy, pulse desc_done; go ARB. Round-robin granularity is one request, not one descriptor.
- Tag pool: TAGS-bit free vector. tag_free_valid sets bit tag_free. Free and allocate in same cycle permitted; a tag freed in cycle t is allocatable in ARB at t+1.
- Address arithmetic 61-bit, no wrap checking; remaining 19-bit, never underflows by construction.

## Timing
- Reset values: r_ready = 0 while reset asserted, = ENABLES from first clock after release; rq_valid 0; desc_done 0; err_tag 0; all tags free; last grant = 7.
- Descriptor strobe cycle t → r_ready[i] low at t+1. Upstream issues per channel at most once per 8 cycles with ≤3 cycles issue-to-strobe latency, so no second strobe reaches a busy slot.
- Strobe at t → earliest ARB at t+1 → rq_valid at t+2.
- Sustained throughput: one request per 2 cycles with rq_ready held high.
- Slot freed on accept at t → r_ready high at t+1, desc_done pulse at t+1.
- Tags exhausted: FSM holds in ARB; rq_valid stays low, no request partially issued.
- Reset asserted mid-operation: slots, tags, FSM cleared immediately; outstanding completions forgotten — completion unit and request queues reset together.

## Configuration
- HIFIFO_READ_SCHED_TAG_CHECK_EN defined: err_tag sets on tag_free of a tag already free or ≥ TAGS, and on r_valid to a busy or disabled channel; cleared only by reset. Offending event otherwise ignored.
- Not defined: err_tag tied 0; same events silently ignored.

## Structure
- hififo_pkg: PAGE_QW = 512, TAG_W function/localparam, descriptor struct {addr[60:0], count[18:0]}, FSM state enum.
- Sub-module hififo_tag_pool: free vector, lowest-free priority encoder, alloc/free ports, tag check logic.

## Test plan
- Ch0 r_addr 0x1000, r_count 200, rq_ready high -> rq_len 64,64,64,8; addrs 0x1000,0x1040,0x1080,0x10C0; desc_done[0] after 4th accept.
- Ch4 r_addr 0x1F0, r_count 40 -> rq_len 16 (at 0x1F0), then 24 (at 0x200): 4 KB split.
- Ch0 and ch4 each 128 qwords loaded together -> requests alternate chan 0,4,0,4; tags 0,1,2,3.
- 32 requests issued, no tags freed -> rq_valid low; tag_free 5 -> next request carries tag 5 within 2 cycles.
- rq_ready low 10 cycles during ISSUE -> rq_addr/len/tag/chan stable; single accept on release.
- Reset low mid-descriptor -> rq_valid, r_ready 0 immediately; after release r_ready = 8'b00010001, tags 0.. reallocated.
